jtag_tap_responder: RTL and testbench
=====================================

Name: jtag_tap_responder

Overview:
- Synthesizable JTAG TAP target model that sits on the tck/tms/tdi/tdo wires opposite the PC-poll initiator.
- Oversamples the JTAG pins in the FPGA clk domain and runs the full 16-state IEEE 1149.1 TAP controller.
- Answers IR scans with a fixed capture pattern.
- Answers DR scans under the PC opcode with a supplied 16-bit PC value; all other opcodes select a 1-bit bypass register.
- Used for loopback self-test of the poller without a target MCU, and as the bench partner for it.

Parameters:
IR_WIDTH, 8, instruction register length in bits
DR_WIDTH, 16, PC data register length in bits
PC_OPCODE, 8'h84, instruction selecting the PC data register
IR_CAPTURE, 8'h89, value loaded into IR shift register in Capture-IR

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  asynchronous, active-high reset
tck  input  1  JTAG clock from initiator (asynchronous to clk)
tms  input  1  JTAG mode select
tdi  input  1  JTAG data in
pc_value  input  DR_WIDTH  value captured in Capture-DR when IR == PC_OPCODE
tdo  output  1  JTAG data out
ir_value  output  IR_WIDTH  current (updated) instruction register
dr_value  output  DR_WIDTH  last data shifted in, latched at Update-DR under PC_OPCODE
dr_update  output  1  one-clk pulse when dr_value is written
tap_state  output  4  current TAP state encoding

Behaviour:
- Reset: tap_state = TEST_LOGIC_RESET (0), ir_value = all ones (bypass), tdo = 0, dr_value = 0, dr_update = 0. Shift registers and synchronizer flops are cleared.
- Synchronizer:
  - tck, tms and tdi each pass through 2 flops.
  - A third tck flop provides edge detection: tck_rise = s2 & ~s3, tck_fall = ~s2 & s3.
  - tms and tdi are used from the s2 stage, i.e. aligned with tck.
  - Requirement on the driver: tck high and low each >= 3 clk periods.
- TAP state encoding:
  - 0 TLR, 1 RTI, 2 SELECT_DR, 3 CAPTURE_DR, 4 SHIFT_DR, 5 EXIT1_DR, 6 PAUSE_DR, 7 EXIT2_DR
  - 8 UPDATE_DR, 9 SELECT_IR, 10 CAPTURE_IR, 11 SHIFT_IR, 12 EXIT1_IR, 13 PAUSE_IR, 14 EXIT2_IR, 15 UPDATE_IR
- State transitions occur on the clk cycle after tck_rise is detected and follow IEEE 1149.1 exactly using the synchronized tms.
- Actions on tck_rise, evaluated in the state before the transition:
  - CAPTURE_IR: ir_shift <= IR_CAPTURE.
  - SHIFT_IR: ir_shift <= {ir_shift[IR_WIDTH-2:0], tdi}. Shifting is MSB first.
  - CAPTURE_DR with ir_value == PC_OPCODE: dr_shift <= pc_value.
  - CAPTURE_DR with any other opcode: bypass <= 0.
  - SHIFT_DR: shift dr_shift MSB-first with tdi in at the LSB, or shift the bypass bit.
  - UPDATE_IR: ir_value <= ir_shift.
  - UPDATE_DR with ir_value == PC_OPCODE: dr_value <= dr_shift, and dr_update = 1 for exactly one clk.
  - TLR: ir_value <= all ones.
- tdo on tck_fall:
  - In SHIFT_IR, tdo = ir_shift MSB.
  - In SHIFT_DR, tdo = dr_shift MSB, or the bypass bit.
  - Otherwise tdo holds its last value.
- Timing: tdo changes within 3 clk of the tck pin falling edge. tap_state changes within 4 clk of the tck pin rising edge.
- Five consecutive tck rises with tms=1 reach TLR from any state.
- Scan-length tolerance:
  - A scan shorter than the register length leaves the remaining bits as captured.
  - A longer scan shifts captured bits out and tdi bits through.
  - Neither case is an error.
- pc_value is sampled only in CAPTURE_DR; changes during a shift have no effect.
- reset asserted mid-scan aborts immediately to the reset values; no dr_update pulse is produced.
- Simultaneous tck_rise and tck_fall cannot occur because they are mutually exclusive by construction.

Test Plan:
- Reset, then 5 tck cycles with tms=1 -> tap_state = 0, ir_value = 8'hFF, tdo = 0, dr_update never asserted.
- IR scan shifting in 8'h84 MSB-first from RTI -> tdo bits read back 8'h89, ir_value = 8'h84 after UPDATE_IR, tap_state returns to 1.
- With IR = 8'h84 and pc_value = 16'h1234, 16-bit DR scan shifting in 16'hA5A5 -> tdo yields 16'h1234 MSB-first, dr_value = 16'hA5A5, one-clk dr_update pulse.
- IR = 8'hFF (bypass), DR scan of 8 bits 10110010 -> tdo = 0 followed by the tdi pattern delayed by one tck, dr_value unchanged.
- pc_value changed from 16'h1234 to 16'hFFFF halfway through SHIFT_DR -> remaining tdo bits still from 16'h1234.
- Assert reset at the 7th bit of a DR scan -> all outputs at reset values next clk; resumed tck pulses with tms=0 then walk the TAP TLR->RTI.

Source files
------------

// File: rtl/jtag_tap_responder.sv
// Purpose: JTAG TAP target that answers IR scans with a fixed pattern and DR scans with a PC value or bypass bit.
// Latency: tap_state settles within 4 clk of a tck pin rise; tdo settles within 3 clk of a tck pin fall.
// Backpressure: none; the tck/tms/tdi pins are always sampled, and tck high/low must each last >= 3 clk.
//
// Ports:
//   clk, reset       system clock, asynchronous active-high reset
//   tck, tms, tdi    JTAG pins from the initiator (asynchronous to clk)
//   pc_value         word loaded into the DR shift register in Capture-DR under PC_OPCODE
//   tdo              JTAG data out, driven on tck falling edges
//   ir_value         current (updated) instruction register
//   dr_value         last DR word latched at Update-DR under PC_OPCODE
//   dr_update        one-clk pulse when dr_value is written
//   tap_state        current TAP state (0 = Test-Logic-Reset ... 15 = Update-IR)
module jtag_tap_responder #(
  parameter int                  IR_WIDTH   = 8,
  parameter int                  DR_WIDTH   = 16,
  parameter logic [IR_WIDTH-1:0] PC_OPCODE  = 8'h84,
  parameter logic [IR_WIDTH-1:0] IR_CAPTURE = 8'h89
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tck,
  input  logic                tms,
  input  logic                tdi,
  input  logic [DR_WIDTH-1:0] pc_value,
  output logic                tdo,
  output logic [IR_WIDTH-1:0] ir_value,
  output logic [DR_WIDTH-1:0] dr_value,
  output logic                dr_update,
  output logic [3:0]          tap_state
);

  typedef enum logic [3:0] {
    TLR        = 4'd0,
    RTI        = 4'd1,
    SELECT_DR  = 4'd2,
    CAPTURE_DR = 4'd3,
    SHIFT_DR   = 4'd4,
    EXIT1_DR   = 4'd5,
    PAUSE_DR   = 4'd6,
    EXIT2_DR   = 4'd7,
    UPDATE_DR  = 4'd8,
    SELECT_IR  = 4'd9,
    CAPTURE_IR = 4'd10,
    SHIFT_IR   = 4'd11,
    EXIT1_IR   = 4'd12,
    PAUSE_IR   = 4'd13,
    EXIT2_IR   = 4'd14,
    UPDATE_IR  = 4'd15
  } tap_state_t;

  // Pin synchronizers. tms/tdi are taken from stage 2 so they line up with
  // the stage-2 tck used for edge detection.
  logic tck_s1, tck_s2, tck_s3;
  logic tms_s1, tms_s2;
  logic tdi_s1, tdi_s2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tck_s1 <= 1'b0;
      tck_s2 <= 1'b0;
      tck_s3 <= 1'b0;
      tms_s1 <= 1'b0;
      tms_s2 <= 1'b0;
      tdi_s1 <= 1'b0;
      tdi_s2 <= 1'b0;
    end else begin
      tck_s1 <= tck;
      tck_s2 <= tck_s1;
      tck_s3 <= tck_s2;
      tms_s1 <= tms;
      tms_s2 <= tms_s1;
      tdi_s1 <= tdi;
      tdi_s2 <= tdi_s1;
    end
  end

  logic tck_rise;
  logic tck_fall;
  assign tck_rise = tck_s2 & ~tck_s3;
  assign tck_fall = ~tck_s2 & tck_s3;

  function automatic tap_state_t next_state(input tap_state_t s, input logic m);
    case (s)
      TLR:        return m ? TLR       : RTI;
      RTI:        return m ? SELECT_DR : RTI;
      SELECT_DR:  return m ? SELECT_IR : CAPTURE_DR;
      CAPTURE_DR: return m ? EXIT1_DR  : SHIFT_DR;
      SHIFT_DR:   return m ? EXIT1_DR  : SHIFT_DR;
      EXIT1_DR:   return m ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:   return m ? EXIT2_DR  : PAUSE_DR;
      EXIT2_DR:   return m ? UPDATE_DR : SHIFT_DR;
      UPDATE_DR:  return m ? SELECT_DR : RTI;
      SELECT_IR:  return m ? TLR       : CAPTURE_IR;
      CAPTURE_IR: return m ? EXIT1_IR  : SHIFT_IR;
      SHIFT_IR:   return m ? EXIT1_IR  : SHIFT_IR;
      EXIT1_IR:   return m ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:   return m ? EXIT2_IR  : PAUSE_IR;
      EXIT2_IR:   return m ? UPDATE_IR : SHIFT_IR;
      UPDATE_IR:  return m ? SELECT_DR : RTI;
      default:    return TLR;
    endcase
  endfunction

  tap_state_t           state_q;
  logic [IR_WIDTH-1:0]  ir_shift;
  logic [DR_WIDTH-1:0]  dr_shift;
  logic                 bypass_q;
  logic                 pc_sel;

  // The DR path is chosen by the already-updated instruction, not ir_shift.
  assign pc_sel    = (ir_value == PC_OPCODE);
  assign tap_state = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= TLR;
      ir_shift  <= '0;
      dr_shift  <= '0;
      bypass_q  <= 1'b0;
      ir_value  <= '1;
      dr_value  <= '0;
      dr_update <= 1'b0;
      tdo       <= 1'b0;
    end else begin
      dr_update <= 1'b0;
      if (tck_rise) begin
        // Actions belong to the state being left on this tck rise.
        case (state_q)
          TLR:        ir_value <= '1;
          CAPTURE_IR: ir_shift <= IR_CAPTURE;
          SHIFT_IR:   ir_shift <= {ir_shift[IR_WIDTH-2:0], tdi_s2};
          CAPTURE_DR: begin
            if (pc_sel) dr_shift <= pc_value;
            else        bypass_q <= 1'b0;
          end
          SHIFT_DR: begin
            if (pc_sel) dr_shift <= {dr_shift[DR_WIDTH-2:0], tdi_s2};
            else        bypass_q <= tdi_s2;
          end
          UPDATE_IR:  ir_value <= ir_shift;
          UPDATE_DR: begin
            if (pc_sel) begin
              dr_value  <= dr_shift;
              dr_update <= 1'b1;
            end
          end
          default: ;
        endcase
        state_q <= next_state(state_q, tms_s2);
      end else if (tck_fall) begin
        // tdo follows the shift register MSB on the falling edge so the
        // initiator sees a stable bit at its next rising edge.
        if (state_q == SHIFT_IR) begin
          tdo <= ir_shift[IR_WIDTH-1];
        end else if (state_q == SHIFT_DR) begin
          tdo <= pc_sel ? dr_shift[DR_WIDTH-1] : bypass_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtag_tap_responder.sv
module tb_jtag_tap_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        tck;
  logic        tms;
  logic        tdi;
  logic [15:0] pc_value;
  logic        tdo;
  logic [7:0]  ir_value;
  logic [15:0] dr_value;
  logic        dr_update;
  logic [3:0]  tap_state;

  always #5 clk = ~clk;

  jtag_tap_responder dut (
    .clk       (clk),
    .reset     (reset),
    .tck       (tck),
    .tms       (tms),
    .tdi       (tdi),
    .pc_value  (pc_value),
    .tdo       (tdo),
    .ir_value  (ir_value),
    .dr_value  (dr_value),
    .dr_update (dr_update),
    .tap_state (tap_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model, advanced once per tck edge rather than per clk.
  int nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  int          m_state;
  logic [7:0]  m_ir, m_ir_sh;
  logic [15:0] m_dr_sh, m_dr;
  logic        m_byp, m_tdo;
  int          m_pulses = 0;
  int          seen_pulses = 0;
  logic        cmp_en = 1'b0;

  task automatic model_reset();
    m_state = 0;
    m_ir    = 8'hFF;
    m_ir_sh = 8'h00;
    m_dr_sh = 16'h0;
    m_dr    = 16'h0;
    m_byp   = 1'b0;
    m_tdo   = 1'b0;
  endtask

  task automatic model_rise(input logic m, input logic d);
    logic pc;
    pc = (m_ir == 8'h84);
    case (m_state)
      0:  m_ir = 8'hFF;
      3:  if (pc) m_dr_sh = pc_value; else m_byp = 1'b0;
      4:  if (pc) m_dr_sh = {m_dr_sh[14:0], d}; else m_byp = d;
      8:  if (pc) begin m_dr = m_dr_sh; m_pulses++; end
      10: m_ir_sh = 8'h89;
      11: m_ir_sh = {m_ir_sh[6:0], d};
      15: m_ir = m_ir_sh;
      default: ;
    endcase
    m_state = m ? nxt1[m_state] : nxt0[m_state];
  endtask

  task automatic model_fall();
    if (m_state == 11) m_tdo = m_ir_sh[7];
    else if (m_state == 4) m_tdo = (m_ir == 8'h84) ? m_dr_sh[15] : m_byp;
  endtask

  // Single compare process: outputs are checked on every clk in which they
  // are settled after the last tck edge.
  always @(negedge clk) begin
    if (dr_update === 1'b1) seen_pulses++;
    if (cmp_en) begin
      check("tap_state", {28'h0, tap_state}, m_state);
      check("ir_value", {24'h0, ir_value}, {24'h0, m_ir});
      check("dr_value", {16'h0, dr_value}, {16'h0, m_dr});
      check("tdo", {31'h0, tdo}, {31'h0, m_tdo});
    end
  end

  // One full tck period with random high/low widths of 4..6 clk.
  task automatic pulse(input logic m, input logic d);
    int h;
    h = $urandom_range(4, 6);
    @(negedge clk);
    cmp_en = 1'b0;
    #1;
    tms = m;
    tdi = d;
    tck = 1'b1;
    model_rise(m, d);
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    repeat (h - 3) @(negedge clk);
    cmp_en = 1'b0;
    #1;
    tck = 1'b0;
    model_fall();
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    repeat (h - 3) @(negedge clk);
  endtask

  // Scan from RTI back to RTI; out collects the n tdo bits, first bit in MSB.
  task automatic scan(input bit is_ir, input int n, input logic [31:0] data,
                      input int chg_at, input logic [15:0] chg_val,
                      output logic [31:0] out);
    out = 32'h0;
    pulse(1'b1, 1'b0);
    if (is_ir) pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b0);
    pulse(1'b0, 1'b0);
    out = {out[30:0], tdo};
    for (int i = 0; i < n; i++) begin
      if (i == chg_at) pc_value = chg_val;
      pulse(i == n - 1, data[n-1-i]);
      if (i < n - 1) out = {out[30:0], tdo};
    end
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: stimulus did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] out;
    reset    = 1'b1;
    tck      = 1'b0;
    tms      = 1'b0;
    tdi      = 1'b0;
    pc_value = 16'h1234;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_tap_state", {28'h0, tap_state}, 32'd0);
    check("rst_ir_value", {24'h0, ir_value}, 32'hFF);
    check("rst_tdo", {31'h0, tdo}, 32'd0);
    check("rst_dr_value", {16'h0, dr_value}, 32'd0);
    check("rst_dr_update", {31'h0, dr_update}, 32'd0);
    reset = 1'b0;

    repeat (5) pulse(1'b1, 1'b0);
    check("tlr_state", {28'h0, tap_state}, 32'd0);
    check("tlr_ir", {24'h0, ir_value}, 32'hFF);
    check("tlr_tdo", {31'h0, tdo}, 32'd0);
    check("tlr_no_update", seen_pulses, 32'd0);
    pulse(1'b0, 1'b0);
    check("rti_state", {28'h0, tap_state}, 32'd1);

    // IR scan loading the PC opcode
    scan(1'b1, 8, 32'h84, -1, 16'h0, out);
    check("ir_capture_bits", {24'h0, out[7:0]}, 32'h89);
    check("ir_after_update", {24'h0, ir_value}, 32'h84);
    check("model_ir_pinned", {24'h0, m_ir}, 32'h84);
    check("ir_back_to_rti", {28'h0, tap_state}, 32'd1);

    // PC DR scan
    pc_value = 16'h1234;
    scan(1'b0, 16, 32'hA5A5, -1, 16'h0, out);
    check("dr_pc_bits", {16'h0, out[15:0]}, 32'h1234);
    check("dr_value_a5a5", {16'h0, dr_value}, 32'hA5A5);
    check("dr_update_once", seen_pulses, 32'd1);

    // Bypass DR scan
    scan(1'b1, 8, 32'hFF, -1, 16'h0, out);
    check("ir_bypass", {24'h0, ir_value}, 32'hFF);
    scan(1'b0, 8, 32'hB2, -1, 16'h0, out);
    check("bypass_bits", {24'h0, out[7:0]}, 32'h59);
    check("bypass_dr_kept", {16'h0, dr_value}, 32'hA5A5);
    check("bypass_no_update", seen_pulses, 32'd1);

    // pc_value change mid-shift has no effect
    scan(1'b1, 8, 32'h84, -1, 16'h0, out);
    pc_value = 16'h1234;
    scan(1'b0, 16, 32'h0F0F, 8, 16'hFFFF, out);
    check("pc_change_bits", {16'h0, out[15:0]}, 32'h1234);
    check("pc_change_dr", {16'h0, dr_value}, 32'h0F0F);
    check("pc_change_update", seen_pulses, 32'd2);

    // Reset during the 7th bit of a DR scan
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b0);
    pulse(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) pulse(1'b0, 1'($urandom));
    @(negedge clk);
    cmp_en = 1'b0;
    #1;
    tdi   = 1'b1;
    tck   = 1'b1;
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    check("abort_state", {28'h0, tap_state}, 32'd0);
    check("abort_ir", {24'h0, ir_value}, 32'hFF);
    check("abort_tdo", {31'h0, tdo}, 32'd0);
    check("abort_dr", {16'h0, dr_value}, 32'd0);
    check("abort_dr_update", {31'h0, dr_update}, 32'd0);
    tck = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    pulse(1'b0, 1'b0);
    check("abort_walk_rti", {28'h0, tap_state}, 32'd1);
    check("abort_no_update", seen_pulses, 32'd2);
    pulse(1'b0, 1'b0);

    // Randomized scans of varying lengths and random TAP walks
    for (int it = 0; it < 30; it++) begin
      logic [31:0] d;
      int n;
      if ($urandom_range(0, 1) == 1) begin
        n = 8;
        d = 32'h84;
      end else begin
        n = $urandom_range(5, 11);
        d = $urandom;
      end
      scan(1'b1, n, d, -1, 16'h0, out);
      pc_value = 16'($urandom);
      n = $urandom_range(1, 24);
      d = $urandom;
      scan(1'b0, n, d, $urandom_range(0, n), 16'($urandom), out);
      if (it % 3 == 0) begin
        repeat (8) pulse(1'($urandom), 1'($urandom));
        repeat (5) pulse(1'b1, 1'($urandom));
        check("five_tms1_to_tlr", {28'h0, tap_state}, 32'd0);
        pulse(1'b0, 1'b0);
      end
    end

    repeat (4) @(negedge clk);
    check("update_pulse_total", seen_pulses, m_pulses);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
